// File: rtl/gtp_daq_rx.sv
// Receive-side DAQ link decoder: acquires sync on idles, parses 3-word frames
// from the GTP receiver, checks checksum/sequence and re-emits 19-bit daq words.
module gtp_daq_rx #(
    parameter int SYNC_COUNT = 16,
    parameter int ERR_LIMIT  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] rx_data,
    input  logic [1:0]  rx_charisk,
    input  logic [1:0]  rx_disperr,
    input  logic [1:0]  rx_notintable,
    input  logic        rx_ready,
    input  logic        err_count_clr,
    output logic [18:0] daq_word,
    output logic        daq_valid,
    output logic        link_up,
    output logic        frame_err,
    output logic        seq_err,
    output logic [15:0] err_count
);

    localparam int SCW = $clog2(SYNC_COUNT + 1);
    localparam int BCW = $clog2(ERR_LIMIT + 1);
    localparam logic [SCW-1:0] SYNC_LAST = SCW'(SYNC_COUNT - 1);
    localparam logic [SCW-1:0] SYNC_ONE  = SCW'(1);
    localparam logic [BCW-1:0] BAD_LAST  = BCW'(ERR_LIMIT - 1);
    localparam logic [BCW-1:0] BAD_ONE   = BCW'(1);

    typedef enum logic [1:0] {
        LS_LOS  = 2'd0,
        LS_HUNT = 2'd1,
        LS_UP   = 2'd2
    } link_state_t;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_DATA = 2'd1,
        FS_END  = 2'd2
    } frame_state_t;

    function automatic logic [7:0] calc_chk(input logic [4:0] seq, input logic [18:0] daq);
        calc_chk = daq[7:0] ^ daq[15:8] ^ {seq, daq[18:16]};
    endfunction

    link_state_t  r_link_st;
    frame_state_t r_frm_st;
    logic [SCW-1:0] r_sync_cnt;
    logic [BCW-1:0] r_bad_cnt;
    logic [4:0]   r_seq;
    logic [2:0]   r_daq_hi;
    logic [15:0]  r_daq_lo;
    logic [4:0]   r_ref_seq;
    logic         r_ref_vld;
    logic [18:0]  r_daq_word;
    logic         r_daq_valid;
    logic         r_link_up;
    logic         r_frame_err;
    logic         r_seq_err;
    logic [15:0]  r_err_count;

    link_state_t  w_link_nxt;
    frame_state_t w_frm_nxt;
    logic [SCW-1:0] w_sync_nxt;
    logic [BCW-1:0] w_bad_nxt;
    logic w_code_err;
    logic w_is_idle;
    logic w_is_w0;
    logic w_is_w1;
    logic w_is_w2;
    logic w_chk_ok;
    logic w_take_w0;
    logic w_take_w1;
    logic w_good;
    logic w_bad;
    logic w_seq_err;

    assign w_code_err = (|rx_disperr) | (|rx_notintable);
    assign w_is_idle  = !w_code_err && rx_charisk == 2'b01 && rx_data == 16'h50BC;
    assign w_is_w0    = !w_code_err && rx_charisk == 2'b01 && rx_data[7:0] == 8'h3C;
    assign w_is_w1    = !w_code_err && rx_charisk == 2'b00;
    assign w_is_w2    = !w_code_err && rx_charisk == 2'b01 && rx_data[7:0] == 8'hF7;
    assign w_chk_ok   = rx_data[15:8] == calc_chk(r_seq, {r_daq_hi, r_daq_lo});
    assign w_seq_err  = w_good && r_ref_vld && (r_seq != (r_ref_seq + 5'd1));

    // Link and frame-parser next state; a dropped rx_ready overrides everything.
    always_comb begin
        w_link_nxt = r_link_st;
        w_frm_nxt  = r_frm_st;
        w_sync_nxt = r_sync_cnt;
        w_bad_nxt  = r_bad_cnt;
        w_take_w0  = 1'b0;
        w_take_w1  = 1'b0;
        w_good     = 1'b0;
        w_bad      = 1'b0;
        if (!rx_ready) begin
            w_link_nxt = LS_LOS;
            w_frm_nxt  = FS_IDLE;
            w_sync_nxt = '0;
            w_bad_nxt  = '0;
        end else begin
            case (r_link_st)
                LS_LOS: begin
                    w_link_nxt = LS_HUNT;
                    w_frm_nxt  = FS_IDLE;
                    w_sync_nxt = '0;
                    w_bad_nxt  = '0;
                end
                LS_HUNT: begin
                    w_frm_nxt = FS_IDLE;
                    w_bad_nxt = '0;
                    if (w_is_idle && r_sync_cnt == SYNC_LAST) begin
                        w_link_nxt = LS_UP;
                        w_sync_nxt = '0;
                    end else if (w_is_idle) begin
                        w_sync_nxt = r_sync_cnt + SYNC_ONE;
                    end else begin
                        w_sync_nxt = '0;
                    end
                end
                LS_UP: begin
                    case (r_frm_st)
                        FS_IDLE: begin
                            if (w_is_idle) begin
                                w_frm_nxt = FS_IDLE;
                            end else if (w_is_w0) begin
                                w_take_w0 = 1'b1;
                                w_frm_nxt = FS_DATA;
                            end else begin
                                w_bad = 1'b1;
                            end
                        end
                        FS_DATA: begin
                            if (w_is_w1) begin
                                w_take_w1 = 1'b1;
                                w_frm_nxt = FS_END;
                            end else begin
                                w_bad = 1'b1;
                            end
                        end
                        FS_END: begin
                            w_frm_nxt = FS_IDLE;
                            if (w_is_w2 && w_chk_ok) begin
                                w_good = 1'b1;
                            end else begin
                                w_bad = 1'b1;
                            end
                        end
                        default: begin
                            w_frm_nxt = FS_IDLE;
                        end
                    endcase
                    if (w_good) begin
                        w_bad_nxt = '0;
                    end else if (w_bad && r_bad_cnt == BAD_LAST) begin
                        w_link_nxt = LS_HUNT;
                        w_frm_nxt  = FS_IDLE;
                        w_sync_nxt = '0;
                        w_bad_nxt  = '0;
                    end else if (w_bad) begin
                        w_frm_nxt = FS_IDLE;
                        w_bad_nxt = r_bad_cnt + BAD_ONE;
                    end else begin
                        w_bad_nxt = r_bad_cnt;
                    end
                end
                default: begin
                    w_link_nxt = LS_LOS;
                    w_frm_nxt  = FS_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_link_st  <= LS_LOS;
            r_frm_st   <= FS_IDLE;
            r_sync_cnt <= '0;
            r_bad_cnt  <= '0;
        end else begin
            r_link_st  <= w_link_nxt;
            r_frm_st   <= w_frm_nxt;
            r_sync_cnt <= w_sync_nxt;
            r_bad_cnt  <= w_bad_nxt;
        end
    end

    // Frame fields captured from W0/W1 until the W2 checksum decides.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seq    <= 5'd0;
            r_daq_hi <= 3'd0;
            r_daq_lo <= 16'd0;
        end else if (w_take_w0) begin
            r_seq    <= rx_data[15:11];
            r_daq_hi <= rx_data[10:8];
        end else if (w_take_w1) begin
            r_daq_lo <= rx_data;
        end
    end

    // The sequence reference is forgotten whenever the link leaves UP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ref_vld <= 1'b0;
            r_ref_seq <= 5'd0;
        end else if (w_link_nxt != LS_UP) begin
            r_ref_vld <= 1'b0;
        end else if (w_good) begin
            r_ref_vld <= 1'b1;
            r_ref_seq <= r_seq;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_daq_word  <= 19'd0;
            r_daq_valid <= 1'b0;
            r_link_up   <= 1'b0;
            r_frame_err <= 1'b0;
            r_seq_err   <= 1'b0;
        end else begin
            r_daq_valid <= w_good;
            r_link_up   <= (w_link_nxt == LS_UP);
            r_frame_err <= w_bad;
            r_seq_err   <= w_seq_err;
            if (w_good) begin
                r_daq_word <= {r_daq_hi, r_daq_lo};
            end
        end
    end

    // Saturating error counter; clear beats a same-cycle increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count <= 16'd0;
        end else if (err_count_clr) begin
            r_err_count <= 16'd0;
        end else if ((w_bad || w_seq_err) && r_err_count != 16'hFFFF) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign daq_word  = r_daq_word;
    assign daq_valid = r_daq_valid;
    assign link_up   = r_link_up;
    assign frame_err = r_frame_err;
    assign seq_err   = r_seq_err;
    assign err_count = r_err_count;

endmodule
